// File: rtl/desc_arb_pkg.sv
// Shared types for the descriptor RAM arbiter: default widths, FSM states, read tag.
// The lock states are only reachable when the design is built with DESC_ARB_LOCK_EN.
package desc_arb_pkg;

    localparam int ADDR_W_DEF = 11;
    localparam int DATA_W_DEF = 32;

    typedef enum logic [1:0] {
        ARB   = 2'd0,
        LOCK0 = 2'd1,
        LOCK1 = 2'd2
    } arb_state_e;

    typedef struct packed {
        logic valid;
        logic port;
    } rd_tag_t;

endpackage

// File: rtl/desc_arb_rr2.sv
// Two-way round-robin grant logic: a lone requester wins, and on a tie the port
// that was not granted last time wins.
module desc_arb_rr2
    import desc_arb_pkg::*;
(
    input  logic [1:0] req_i,
    input  logic       last_grant_i,
    output logic [1:0] grant_o
);

    always_comb begin
        grant_o = req_i;
        if (req_i == 2'b11) begin
            grant_o = last_grant_i ? 2'b01 : 2'b10;
        end
    end

endmodule

// File: rtl/desc_mem_arbiter.sv
// Two-master Avalon-MM arbiter (CPU = port 0, AVB descriptor DMA = port 1) in front of the
// single-port descriptor RAM. Define DESC_ARB_LOCK_EN to add p0_lock/p1_lock atomic locking.
//
// state | meaning
// ARB   | per-transaction round-robin between the two ports
// LOCK0 | port 0 owns the RAM; port 1 is held off
// LOCK1 | port 1 owns the RAM; port 0 is held off
module desc_mem_arbiter
    import desc_arb_pkg::*;
#(
    parameter int  ADDR_W       = ADDR_W_DEF,
    parameter int  DATA_W       = DATA_W_DEF,
    parameter int  LOCK_TIMEOUT = 16,
    localparam int BE_W         = DATA_W / 8
) (
    input  logic              clk,
    input  logic              reset_n,

    input  logic [ADDR_W-1:0] p0_address,
    input  logic [BE_W-1:0]   p0_byteenable,
    input  logic              p0_read,
    input  logic              p0_write,
    input  logic [DATA_W-1:0] p0_writedata,
    output logic              p0_waitrequest,
    output logic [DATA_W-1:0] p0_readdata,
    output logic              p0_readdatavalid,

    input  logic [ADDR_W-1:0] p1_address,
    input  logic [BE_W-1:0]   p1_byteenable,
    input  logic              p1_read,
    input  logic              p1_write,
    input  logic [DATA_W-1:0] p1_writedata,
    output logic              p1_waitrequest,
    output logic [DATA_W-1:0] p1_readdata,
    output logic              p1_readdatavalid,
`ifdef DESC_ARB_LOCK_EN
    input  logic              p0_lock,
    input  logic              p1_lock,
`endif
    output logic [ADDR_W-1:0] ram_address,
    output logic [BE_W-1:0]   ram_byteenable,
    output logic              ram_chipselect,
    output logic              ram_write,
    output logic [DATA_W-1:0] ram_writedata,
    output logic              ram_clken,
    input  logic [DATA_W-1:0] ram_readdata
);

    if (LOCK_TIMEOUT < 2) begin : g_lock_timeout_too_small
    end

    arb_state_e state_q, state_d;
    logic       last_grant_q, last_grant_d;
    rd_tag_t    tag_q, tag_d;
    logic [1:0] req;
    logic [1:0] rr_grant;
    logic [1:0] grant;
    logic       sel;
    logic       rd_accept;

`ifdef DESC_ARB_LOCK_EN
    localparam int CNT_W = $clog2(LOCK_TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
    logic [CNT_W-1:0] cnt_q, cnt_d;
`endif

    assign req = {p1_read | p1_write, p0_read | p0_write};

    desc_arb_rr2 u_rr2 (
        .req_i        (req),
        .last_grant_i (last_grant_q),
        .grant_o      (rr_grant)
    );

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        grant        = rr_grant;
`ifdef DESC_ARB_LOCK_EN
        cnt_d        = cnt_q;
        case (state_q)
            LOCK0:   grant = {1'b0, req[0]};
            LOCK1:   grant = {req[1], 1'b0};
            default: grant = rr_grant;
        endcase
`endif
        // Nothing is accepted while reset is held, so waitrequest reads 1 on both ports.
        if (!reset_n) begin
            grant = 2'b00;
        end
        if (grant != 2'b00) begin
            last_grant_d = grant[1];
        end
`ifdef DESC_ARB_LOCK_EN
        case (state_q)
            LOCK0: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_LAST) begin
                    state_d      = ARB;
                    last_grant_d = 1'b0;
                end else if (!p0_lock && (grant[0] || !req[0])) begin
                    state_d = ARB;
                end
            end
            LOCK1: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_LAST) begin
                    state_d      = ARB;
                    last_grant_d = 1'b1;
                end else if (!p1_lock && (grant[1] || !req[1])) begin
                    state_d = ARB;
                end
            end
            default: begin
                if (grant[0] && p0_lock) begin
                    state_d = LOCK0;
                    cnt_d   = '0;
                end else if (grant[1] && p1_lock) begin
                    state_d = LOCK1;
                    cnt_d   = '0;
                end
            end
        endcase
`endif
    end

    // With no grant the mux parks on the last winner; the RAM ignores it (chipselect low).
    assign sel = grant[1] | (~grant[0] & last_grant_q);

    assign ram_address    = sel ? p1_address    : p0_address;
    assign ram_byteenable = sel ? p1_byteenable : p0_byteenable;
    assign ram_writedata  = sel ? p1_writedata  : p0_writedata;
    assign ram_chipselect = |grant;
    assign ram_write      = (grant[0] & p0_write) | (grant[1] & p1_write);
    assign ram_clken      = 1'b1;

    assign p0_waitrequest = ~grant[0];
    assign p1_waitrequest = ~grant[1];

    assign rd_accept = (grant[0] & p0_read & ~p0_write) | (grant[1] & p1_read & ~p1_write);
    assign tag_d     = '{valid: rd_accept, port: grant[1]};

    assign p0_readdata      = ram_readdata;
    assign p1_readdata      = ram_readdata;
    assign p0_readdatavalid = tag_q.valid & ~tag_q.port;
    assign p1_readdatavalid = tag_q.valid &  tag_q.port;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ARB;
            last_grant_q <= 1'b1;
            tag_q        <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            tag_q        <= tag_d;
        end
    end

`ifdef DESC_ARB_LOCK_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`endif

endmodule

// File: tb/tb_desc_mem_arbiter.sv
// Self-checking bench for desc_mem_arbiter: reset table, directed sequences, random traffic
// against a transaction-level model of the arbiter and RAM.
module tb_desc_mem_arbiter;

    localparam int ADDR_W = 11;
    localparam int DATA_W = 32;
    localparam int BE_W   = 4;

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic [ADDR_W-1:0] p0_address = '0, p1_address = '0;
    logic [BE_W-1:0]   p0_byteenable = '0, p1_byteenable = '0;
    logic              p0_read = 1'b0, p0_write = 1'b0, p1_read = 1'b0, p1_write = 1'b0;
    logic [DATA_W-1:0] p0_writedata = '0, p1_writedata = '0;
    logic              p0_waitrequest, p1_waitrequest, p0_readdatavalid, p1_readdatavalid;
    logic [DATA_W-1:0] p0_readdata, p1_readdata;
    logic              p0_lock = 1'b0, p1_lock = 1'b0;
    logic [ADDR_W-1:0] ram_address;
    logic [BE_W-1:0]   ram_byteenable;
    logic              ram_chipselect, ram_write, ram_clken;
    logic [DATA_W-1:0] ram_writedata, ram_readdata;

    always #5 clk = ~clk;

    desc_mem_arbiter dut (
        .clk(clk), .reset_n(reset_n),
        .p0_address(p0_address), .p0_byteenable(p0_byteenable), .p0_read(p0_read),
        .p0_write(p0_write), .p0_writedata(p0_writedata), .p0_waitrequest(p0_waitrequest),
        .p0_readdata(p0_readdata), .p0_readdatavalid(p0_readdatavalid),
        .p1_address(p1_address), .p1_byteenable(p1_byteenable), .p1_read(p1_read),
        .p1_write(p1_write), .p1_writedata(p1_writedata), .p1_waitrequest(p1_waitrequest),
        .p1_readdata(p1_readdata), .p1_readdatavalid(p1_readdatavalid),
`ifdef DESC_ARB_LOCK_EN
        .p0_lock(p0_lock), .p1_lock(p1_lock),
`endif
        .ram_address(ram_address), .ram_byteenable(ram_byteenable),
        .ram_chipselect(ram_chipselect), .ram_write(ram_write),
        .ram_writedata(ram_writedata), .ram_clken(ram_clken), .ram_readdata(ram_readdata)
    );

    // Synchronous-read RAM: data for an address presented in cycle N appears in cycle N+1.
    logic [DATA_W-1:0] ram_mem [0:2047];
    logic [DATA_W-1:0] ram_q = '0;
    assign ram_readdata = ram_q;
    always @(posedge clk) begin
        if (ram_chipselect) begin
            if (ram_write) begin
                for (int b = 0; b < BE_W; b++)
                    if (ram_byteenable[b]) ram_mem[ram_address][8*b +: 8] <= ram_writedata[8*b +: 8];
            end else begin
                ram_q <= ram_mem[ram_address];
            end
        end
    end

    int total = 0;
    int bad   = 0;

    // Reference model: memory contents, last winner, read outstanding for next cycle.
    logic [DATA_W-1:0] ref_mem [0:2047];
    int                m_last = 1;
    bit                m_pend_v = 1'b0;
    int                m_pend_port = 0;
    logic [DATA_W-1:0] m_pend_data = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic set_idle();
        p0_read = 0; p0_write = 0; p1_read = 0; p1_write = 0;
        p0_lock = 0; p1_lock = 0;
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        set_idle();
        reset_n = 0;
        @(posedge clk); @(posedge clk); #5;
        reset_n = 1;
        m_last = 1;
        m_pend_v = 0;
    endtask

    // One bus cycle: drive, compare every visible output against the model, then advance it.
    task automatic step(input bit r0, input bit w0, input logic [ADDR_W-1:0] a0,
                        input logic [BE_W-1:0] be0, input logic [DATA_W-1:0] d0,
                        input bit r1, input bit w1, input logic [ADDR_W-1:0] a1,
                        input logic [BE_W-1:0] be1, input logic [DATA_W-1:0] d1,
                        output int g, output logic [DATA_W-1:0] rdata_seen);
        bit q0, q1, is_w;
        logic [ADDR_W-1:0] ga;
        logic [BE_W-1:0]   gbe;
        logic [DATA_W-1:0] gd;
        @(posedge clk); #1;
        p0_read = r0; p0_write = w0; p0_address = a0; p0_byteenable = be0; p0_writedata = d0;
        p1_read = r1; p1_write = w1; p1_address = a1; p1_byteenable = be1; p1_writedata = d1;
        #4;
        q0 = r0 | w0;
        q1 = r1 | w1;
        g  = -1;
        if (q0 && q1) g = (m_last == 0) ? 1 : 0;
        else if (q0)  g = 0;
        else if (q1)  g = 1;
        check("wait0", p0_waitrequest, (g == 0) ? 0 : 1);
        check("wait1", p1_waitrequest, (g == 1) ? 0 : 1);
        check("cs", ram_chipselect, (g >= 0) ? 1 : 0);
        is_w = (g == 0) ? w0 : (g == 1) ? w1 : 1'b0;
        check("we", ram_write, is_w);
        ga  = (g == 1) ? a1 : a0;
        gbe = (g == 1) ? be1 : be0;
        gd  = (g == 1) ? d1 : d0;
        if (g >= 0) begin
            check("addr", ram_address, ga);
            if (is_w) begin
                check("be", ram_byteenable, gbe);
                check("wdata", ram_writedata, gd);
            end
        end
        check("rdv0", p0_readdatavalid, m_pend_v && m_pend_port == 0);
        check("rdv1", p1_readdatavalid, m_pend_v && m_pend_port == 1);
        rdata_seen = (m_pend_port == 1) ? p1_readdata : p0_readdata;
        if (m_pend_v) check("rdata", rdata_seen, m_pend_data);
        m_pend_v = 0;
        if (g >= 0) begin
            m_last = g;
            if (is_w) begin
                for (int b = 0; b < BE_W; b++)
                    if (gbe[b]) ref_mem[ga][8*b +: 8] = gd[8*b +: 8];
            end else begin
                m_pend_v    = 1;
                m_pend_port = g;
                m_pend_data = ref_mem[ga];
            end
        end
    endtask

    typedef struct {
        bit r0, w0, r1, w1;
        bit wt0, wt1, cs, we, rdv0, rdv1;
    } vec_t;

    vec_t tbl [9];

    initial begin
        int g, acc;
        logic [DATA_W-1:0] rd;

        for (int i = 0; i < 2048; i++) begin
            ram_mem[i] = '0;
            ref_mem[i] = '0;
        end
        //         r0 w0 r1 w1  wt0 wt1 cs we rdv0 rdv1
        tbl[0] = '{0, 0, 0, 0,  1, 1, 0, 0, 0, 0};
        tbl[1] = '{1, 0, 1, 0,  0, 1, 1, 0, 0, 0};
        tbl[2] = '{1, 0, 1, 0,  1, 0, 1, 0, 1, 0};
        tbl[3] = '{0, 1, 0, 0,  0, 1, 1, 1, 0, 1};
        tbl[4] = '{0, 1, 0, 0,  0, 1, 1, 1, 0, 0};
        tbl[5] = '{1, 1, 1, 0,  1, 0, 1, 0, 0, 0};
        tbl[6] = '{1, 1, 0, 0,  0, 1, 1, 1, 0, 1};
        tbl[7] = '{0, 0, 1, 0,  1, 0, 1, 0, 0, 0};
        tbl[8] = '{0, 0, 0, 0,  1, 1, 0, 0, 0, 1};

        // Requests held high during reset must not be accepted.
        p0_read = 1; p1_read = 1;
        #12;
        check("rst_wait0", p0_waitrequest, 1);
        check("rst_wait1", p1_waitrequest, 1);
        check("rst_rdv0", p0_readdatavalid, 0);
        check("rst_rdv1", p1_readdatavalid, 0);
        check("rst_cs", ram_chipselect, 0);
        check("clken", ram_clken, 1);
        set_idle();
        #3 reset_n = 1;

        // Byteenable 0 keeps the table's writes from disturbing memory.
        p0_address = 11'h7F0; p1_address = 11'h7F1;
        p0_byteenable = 4'h0; p1_byteenable = 4'h0;
        for (int i = 0; i < 9; i++) begin
            @(posedge clk); #1;
            p0_read = tbl[i].r0; p0_write = tbl[i].w0;
            p1_read = tbl[i].r1; p1_write = tbl[i].w1;
            #4;
            check($sformatf("tbl%0d_wait0", i), p0_waitrequest, tbl[i].wt0);
            check($sformatf("tbl%0d_wait1", i), p1_waitrequest, tbl[i].wt1);
            check($sformatf("tbl%0d_cs", i), ram_chipselect, tbl[i].cs);
            check($sformatf("tbl%0d_we", i), ram_write, tbl[i].we);
            check($sformatf("tbl%0d_rdv0", i), p0_readdatavalid, tbl[i].rdv0);
            check($sformatf("tbl%0d_rdv1", i), p1_readdatavalid, tbl[i].rdv1);
        end

        do_reset();
        step(0, 1, 11'h005, 4'hF, 32'hDEADBEEF, 0, 0, '0, '0, '0, g, rd);
        check("wr_grant", g, 0);
        step(0, 0, '0, '0, '0, 0, 0, '0, '0, '0, g, rd);
        step(0, 0, '0, '0, '0, 1, 0, 11'h005, 4'hF, '0, g, rd);
        step(0, 0, '0, '0, '0, 0, 0, '0, '0, '0, g, rd);
        check("rd_deadbeef", rd, 32'hDEADBEEF);

        acc = 0;
        for (int i = 0; i < 8; i++) begin
            step(1, 0, ADDR_W'(i), 4'hF, '0, 1, 0, ADDR_W'(16 + i), 4'hF, '0, g, rd);
            check($sformatf("alt%0d_grant", i), g, i % 2);
            if (g >= 0) acc++;
        end
        check("alt_accepts", acc, 8);
        step(0, 0, '0, '0, '0, 0, 0, '0, '0, '0, g, rd);

        step(1, 1, 11'h020, 4'hF, 32'h11223344, 0, 0, '0, '0, '0, g, rd);
        step(0, 1, 11'h020, 4'b0010, 32'h0000AB00, 0, 0, '0, '0, '0, g, rd);
        step(0, 0, '0, '0, '0, 1, 0, 11'h020, 4'hF, '0, g, rd);
        step(0, 0, '0, '0, '0, 0, 0, '0, '0, '0, g, rd);
        check("be_merge", rd, 32'h1122AB44);

        // Reset in the cycle a p1 read response is due must swallow it.
        step(0, 0, '0, '0, '0, 1, 0, 11'h005, 4'hF, '0, g, rd);
        @(posedge clk); #1;
        set_idle();
        reset_n = 0;
        #4;
        check("rstrd_rdv1", p1_readdatavalid, 0);
        check("rstrd_wait1", p1_waitrequest, 1);
        @(posedge clk); #4;
        check("rstrd_rdv1_b", p1_readdatavalid, 0);
        #1 reset_n = 1;
        m_last = 1;
        m_pend_v = 0;
        step(1, 0, 11'h001, 4'hF, '0, 1, 0, 11'h002, 4'hF, '0, g, rd);
        check("post_rst_tie", g, 0);

        for (int i = 0; i < 300; i++) begin
            int k0, k1;
            k0 = $urandom_range(0, 4);
            k1 = $urandom_range(0, 4);
            step(k0 == 1 || k0 == 2 || k0 == 4, k0 >= 3, ADDR_W'($urandom_range(0, 15)),
                 BE_W'($urandom), $urandom,
                 k1 == 1 || k1 == 2 || k1 == 4, k1 >= 3, ADDR_W'($urandom_range(0, 15)),
                 BE_W'($urandom), $urandom, g, rd);
        end
        step(0, 0, '0, '0, '0, 0, 0, '0, '0, '0, g, rd);

`ifdef DESC_ARB_LOCK_EN
        do_reset();
        @(posedge clk); #1;
        p1_read = 1; p1_lock = 1;
        #4 check("lk_acc1", p1_waitrequest, 0);
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            p0_read = 1; p1_read = 0; p1_write = 0; p1_lock = 1;
            #4 check($sformatf("lk_hold%0d", k), p0_waitrequest, 1);
        end
        @(posedge clk); #1;
        p0_read = 1; p1_write = 1; p1_lock = 0;
        #4;
        check("lk_unlock_wr", p1_waitrequest, 0);
        check("lk_unlock_p0", p0_waitrequest, 1);
        @(posedge clk); #1;
        p0_read = 1; p1_write = 0;
        #4 check("lk_p0_next", p0_waitrequest, 0);

        do_reset();
        @(posedge clk); #1;
        p1_read = 1; p1_lock = 1;
        #4 check("to_acc1", p1_waitrequest, 0);
        for (int k = 1; k <= 17; k++) begin
            @(posedge clk); #1;
            p0_read = 1; p1_read = 0; p1_lock = 1;
            #4 check($sformatf("to_wait0_c%0d", k), p0_waitrequest, (k <= 16) ? 1 : 0);
        end
        set_idle();
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/desc_mem_arbiter.md
Name: desc_mem_arbiter

Overview:
- Two-master arbiter in front of the 2048x32 single-port descriptor RAM.
- Shares the RAM between the CPU (port 0) and the AVB DMA descriptor engine (port 1).
- Each port is an Avalon-MM slave with waitrequest and readdatavalid; one RAM-side master port drives the RAM.
- Per-transaction round-robin arbitration; reads are pipelined with fixed latency.

Parameters:
- ADDR_W, 11, word address width (2048 words)
- DATA_W, 32, data width; BE_W = DATA_W/8
- LOCK_TIMEOUT, 16, max cycles a lock may hold the grant (used only with the optional feature)

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- p0_address / p1_address  in  ADDR_W  word address
- p0_byteenable / p1_byteenable  in  BE_W  byte lanes
- p0_read / p1_read  in  1  read request
- p0_write / p1_write  in  1  write request
- p0_writedata / p1_writedata  in  DATA_W  write data
- p0_waitrequest / p1_waitrequest  out  1  high = request not accepted this cycle
- p0_readdata / p1_readdata  out  DATA_W  read data
- p0_readdatavalid / p1_readdatavalid  out  1  read data valid strobe
- ram_address  out  ADDR_W  to RAM
- ram_byteenable  out  BE_W  to RAM
- ram_chipselect  out  1  to RAM
- ram_write  out  1  to RAM
- ram_writedata  out  DATA_W  to RAM
- ram_clken  out  1  RAM clock enable; constant 1
- ram_readdata  in  DATA_W  from RAM; unregistered output, valid the cycle after the address
- p0_lock / p1_lock  in  1  present only with DESC_ARB_LOCK_EN

Behaviour:
- Request: reqN = pN_read | pN_write. pN_read and pN_write both high is illegal; treat it as a write.
- Arbitration is combinational within the cycle. The selected port's address, byteenable, writedata and write drive the RAM mux, and ram_chipselect = 1.
  - Accepted port: pN_waitrequest = 0.
  - Every other port: waitrequest = 1, including idle ports.
- Round-robin: registered last_grant; reset value 1, so port 0 wins the first tie.
  - Only one requester: it is granted.
  - Both requesting: the port != last_grant is granted.
  - last_grant updates on every accepted transaction.
- No request: ram_chipselect = 0 and ram_write = 0; RAM address/data hold the last value (don't-care).
- Read latency is exactly 1 cycle. A read accepted in cycle N produces pN_readdatavalid = 1 in cycle N+1.
  - Valid flags come from a registered read tag (valid + port id).
  - pN_readdata = ram_readdata for both ports; only readdatavalid is qualified.
- Back-to-back reads from alternating ports are fully pipelined: one accept per cycle, no bubbles.
- Writes complete on accept and produce no response.
- Reset values: readdatavalid = 0 on both ports, read tag invalid, last_grant = 1, FSM = ARB. waitrequest follows the combinational rule; it is 1 while reset is asserted.
- Reset mid-read: the pending readdatavalid is dropped and never issued.
- FSM states: ARB (round-robin), LOCK0, LOCK1. Without the optional feature the FSM stays in ARB permanently.

Optional Feature:
- Macro DESC_ARB_LOCK_EN; adds the p0_lock/p1_lock ports. Purpose: atomic read-modify-write of a descriptor ownership word.
- ARB -> LOCKn: on an accepted transaction from port n with pn_lock = 1. Lock counter clears to 0.
- In LOCKn:
  - Port n is always granted when it requests.
  - The other port sees waitrequest = 1.
  - Counter increments every cycle.
- LOCKn -> ARB on any of:
  - an accepted port-n transaction with pn_lock = 0 (that transaction is part of the lock);
  - reqn = 0 with pn_lock = 0;
  - counter reaching LOCK_TIMEOUT-1 (forced release; last_grant = n).
- Without the macro: the ports are absent and lock logic is not synthesised.

Decomposition:
- Shared package desc_arb_pkg holds:
  - ADDR_W, DATA_W defaults;
  - FSM state enum (ARB, LOCK0, LOCK1);
  - read-tag struct {valid, port}.
- One natural sub-module: desc_arb_rr2, the 2-way round-robin grant logic (req[1:0], last_grant -> grant[1:0]).
- The mux and the read-tag pipeline stay in the top level.

Test Plan:
- Reset, then p0 write addr 0x005 data 0xDEADBEEF be 4'hF -> p0_waitrequest = 0 same cycle, ram_write = 1; a later p1 read of 0x005 -> p1_readdatavalid one cycle after accept, data 0xDEADBEEF.
- p0 and p1 both read every cycle for 8 cycles -> grants alternate p0, p1, ...; 8 accepts in 8 cycles; each readdatavalid on the correct port 1 cycle later.
- Byteenable 4'b0010 write of 0x0000AB00 over 0x11223344 -> readback 0x1122AB44.
- Assert reset_n = 0 the cycle after a p1 read is accepted -> no p1_readdatavalid; after reset, first tie goes to p0.
- (DESC_ARB_LOCK_EN) p1 read with lock, p0 requesting continuously -> p0 waitrequest stays 1 until p1's unlocked write is accepted, then p0 is granted next.
- (DESC_ARB_LOCK_EN) p1 locks, then idles with lock = 1 -> release after LOCK_TIMEOUT = 16 cycles, p0 is granted on the following cycle.
